// File: rtl/shader_pkg.sv
// Shared encodings and alpha helpers for the shader program sequencer.
package shader_pkg;

    localparam logic [1:0] MODE_AUTO     = 2'b00;
    localparam logic [1:0] MODE_MANUAL   = 2'b01;
    localparam logic [1:0] MODE_HOLD     = 2'b10;
    localparam logic [1:0] MODE_PINGPONG = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FADE  = 2'd2;

    localparam int ALPHA_W = 8;
    localparam logic [ALPHA_W-1:0] ALPHA_MAX = 8'd255;

    // Widen by one bit so the carry out of the sum selects saturation.
    function automatic logic [ALPHA_W-1:0] alpha_add(input logic [ALPHA_W-1:0] a,
                                                     input logic [ALPHA_W-1:0] inc);
        logic [ALPHA_W:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return sum[ALPHA_W] ? ALPHA_MAX : sum[ALPHA_W-1:0];
    endfunction

endpackage

// File: rtl/shader_period_timer.sv
// Dwell counter: wraps at PERIOD-1 and flags an expiry in that same cycle.
module shader_period_timer #(
    parameter int PERIOD = 12_500_000,
    parameter int CNT_W  = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expiry_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expiry_o = en_i && !clr_i && (count_q == CNT_W'(PERIOD - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = expiry_o ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/shader_sequencer.sv
// Shader program sequencer: collects switch requests, applies them at frame
// start only, then ramps a per-frame crossfade weight for the blender.
module shader_sequencer
    import shader_pkg::*;
#(
    parameter int NUM_SHADERS = 6,
    parameter int SEL_W       = 4,
    parameter int PERIOD      = 12_500_000,
    parameter int CNT_W       = 24,
    parameter int FADE_STEP   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start_i,
    input  logic [1:0]       mode_i,
    input  logic             step_i,
    output logic [SEL_W-1:0] sel_cur_o,
    output logic [SEL_W-1:0] sel_prev_o,
    output logic [7:0]       alpha_o,
    output logic             fading_o,
    output logic             switch_pulse_o
);

    localparam logic [ALPHA_W-1:0] FADE_INC = ALPHA_W'(FADE_STEP);
    localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(NUM_SHADERS - 1);

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   selCur_q, selCur_d;
    logic [SEL_W-1:0]   selPrev_q, selPrev_d;
    logic [ALPHA_W-1:0] alpha_q, alpha_d;
    logic               fading_q, fading_d;
    logic               pulse_q, pulse_d;
    logic               pending_q, pending_d;
    logic               dirDown_q, dirDown_d;
    logic [1:0]         mode_q;

    logic               modeChanged;
    logic               timerEn;
    logic               timerClr;
    logic               expiry;
    logic               request;
    logic               consume;
    logic [SEL_W-1:0]   nextSel;
    logic               nextDirDown;
    logic               goDown;

    assign modeChanged = (mode_i != mode_q);
    assign timerEn     = (mode_i == MODE_AUTO) || (mode_i == MODE_PINGPONG);
    assign timerClr    = modeChanged || (mode_i == MODE_MANUAL);
    assign request     = (expiry && timerEn) || (step_i && (mode_i == MODE_MANUAL));

    shader_period_timer #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en_i     (timerEn),
        .clr_i    (timerClr),
        .expiry_o (expiry)
    );

    // Ping-pong bounces off either end; the stored direction only matters in between.
    always_comb begin
        goDown      = 1'b0;
        nextDirDown = dirDown_q;
        if (mode_i == MODE_PINGPONG) begin
            goDown      = (selCur_q == LAST_SEL) || (dirDown_q && (selCur_q != '0));
            nextDirDown = goDown;
            nextSel     = goDown ? selCur_q - SEL_W'(1) : selCur_q + SEL_W'(1);
        end else begin
            nextSel = (selCur_q == LAST_SEL) ? '0 : selCur_q + SEL_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        selCur_d  = selCur_q;
        selPrev_d = selPrev_q;
        alpha_d   = alpha_q;
        fading_d  = fading_q;
        dirDown_d = dirDown_q;
        consume   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                alpha_d  = ALPHA_MAX;
                fading_d = 1'b0;
                if (pending_q) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_start_i) begin
                    selPrev_d = selCur_q;
                    selCur_d  = nextSel;
                    dirDown_d = nextDirDown;
                    alpha_d   = '0;
                    fading_d  = 1'b1;
                    consume   = 1'b1;
                    state_d   = ST_FADE;
                end
            end
            ST_FADE: begin
                if (frame_start_i) begin
                    alpha_d = alpha_add(alpha_q, FADE_INC);
                    if (alpha_d == ALPHA_MAX) begin
                        fading_d = 1'b0;
                        state_d  = pending_q ? ST_ARMED : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pending_d = request || (pending_q && !consume);
        pulse_d   = consume;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            selCur_q  <= '0;
            selPrev_q <= '0;
            alpha_q   <= ALPHA_MAX;
            fading_q  <= 1'b0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
            dirDown_q <= 1'b0;
            mode_q    <= MODE_AUTO;
        end else begin
            state_q   <= state_d;
            selCur_q  <= selCur_d;
            selPrev_q <= selPrev_d;
            alpha_q   <= alpha_d;
            fading_q  <= fading_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            dirDown_q <= dirDown_d;
            mode_q    <= mode_i;
        end
    end

    assign sel_cur_o      = selCur_q;
    assign sel_prev_o     = selPrev_q;
    assign alpha_o        = alpha_q;
    assign fading_o       = fading_q;
    assign switch_pulse_o = pulse_q;

endmodule

// File: doc/shader_sequencer.md
# shader_sequencer

Parametrised shader-program sequencer driving the pixel pipeline's shader select. Supports auto-advance, manual stepping, hold and ping-pong modes. Switches are applied only at frame start, so a program never changes mid-frame, and each switch is followed by a frame-stepped crossfade factor for the blender. It sits between the timing generator (frame_start) and the shader/blend stage.

## Interface
Parameters:
- NUM_SHADERS, 6, number of programs; legal range 2..2^SEL_W
- SEL_W, 4, width of select outputs
- PERIOD, 12_500_000, auto-mode dwell in clk cycles; at least 2
- CNT_W, 24, period counter width; 2^CNT_W must be greater than PERIOD
- FADE_STEP, 16, alpha increment per frame; 1..255

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse at the first pixel of each frame
- mode  in  2  00 auto, 01 manual, 10 hold, 11 ping-pong
- step  in  1  one-cycle manual advance request; honoured in manual mode only
- sel_cur  out  SEL_W  incoming/current program
- sel_prev  out  SEL_W  outgoing program during fade
- alpha  out  8  blend weight of sel_cur; 255 means sel_cur only
- fading  out  1  high while a fade is in progress
- switch_pulse  out  1  one-cycle pulse when sel_cur changes

## Operation
- Reset values: sel_cur=0, sel_prev=0, alpha=255, fading=0, switch_pulse=0, state IDLE, direction up, counter 0, pending 0.
- Period timer:
  - Counts clk cycles in auto and ping-pong modes.
  - When the count reaches PERIOD-1, it wraps to 0 and emits an expiry. Expiries are therefore exactly PERIOD cycles apart.
  - In manual mode the timer is held at 0. In hold mode it is frozen.
  - Any change of mode clears the timer to 0.
- Request sources:
  - Timer expiry in auto and ping-pong modes.
  - step in manual mode.
  - In hold mode, step is ignored and no requests arise; an existing pending request stays pending and is applied.
- Pending flag:
  - Requests set a single pending flag.
  - Simultaneous sources, or further requests while pending=1, collapse into one request.
- Next index:
  - auto and manual: (sel_cur+1) mod NUM_SHADERS.
  - ping-pong: step in the current direction. At NUM_SHADERS-1 the direction flips to down, and at 0 it flips to up, so the sequence runs 0,1,…,N-1,N-2,…,1,0,1…
- States:
  - IDLE: alpha=255, fading=0. pending=1 moves to ARMED.
  - ARMED: wait for frame_start. On frame_start: sel_prev←sel_cur, sel_cur←next, alpha←0, fading←1, switch_pulse=1, pending←0, move to FADE.
  - FADE: on each frame_start, alpha←min(alpha+FADE_STEP, 255) using a 9-bit sum then saturate. When the result is 255: fading←0, move to IDLE if pending=0, otherwise ARMED.
- Requests arriving during FADE are held pending. A pending request is never applied before the current fade completes.
- Reset mid-fade returns immediately to reset values.

## Timing
- Registered outputs. A frame_start sampled at cycle t produces new sel_cur, sel_prev, alpha and switch_pulse at cycle t+1.
- The pending flag is set at cycle t+1 for a request generated at cycle t.
- A frame_start coinciding with the request cycle does not consume that request. It is consumed at the next frame_start.
- Minimum request-to-switch latency: 2 cycles plus the wait to the next frame_start.
- Fade duration: ceil(255/FADE_STEP) frames. With FADE_STEP=255, alpha goes 0 then 255 on the following frame.
- switch_pulse is high for exactly one cycle per switch.

## Structure
- Shared package shader_pkg holds:
  - mode encodings (MODE_AUTO, MODE_MANUAL, MODE_HOLD, MODE_PINGPONG)
  - the state encoding
  - ALPHA_W=8 and ALPHA_MAX=255
- Sub-module shader_period_timer (params PERIOD, CNT_W; inputs en, clr; output expiry) encapsulates the dwell counter.
- The FSM, pending logic and index/direction logic live in the top.

## Test plan
- Auto, PERIOD=10, frame_start every 4 cycles, FADE_STEP=255 -> expiries every 10 cycles; sel_cur steps 0,1,2,3,4,5,0. Each switch occurs the cycle after a frame_start, and switch_pulse is one cycle wide.
- Ping-pong, NUM_SHADERS=3, fast frames -> sel_cur sequence 1,2,1,0,1,2.
- Manual, FADE_STEP=64: step, then frame_start -> sel_prev=0, sel_cur=1, alpha=0. Subsequent frame_starts give alpha 64,128,192,255, and fading drops when alpha reaches 255. Two steps issued during the fade -> exactly one further switch, on the first frame_start after alpha=255.
- Step and frame_start asserted in the same cycle from IDLE -> no switch on that frame; switch on the next frame_start.
- Hold entered with pending=1 -> pending switch applied at next frame_start, then no further switches. Return to auto -> first expiry exactly PERIOD cycles after the mode change.
- rst asserted mid-fade (alpha=128) -> outputs return asynchronously to sel_cur=0, alpha=255, fading=0, with no switch_pulse after release until a new request.
